// File: rtl/axis_uart_tx_pkt.sv
// axis_uart_tx_pkt
//
// AXI-Stream to UART transmitter. Each accepted beat becomes one frame: a start bit,
// WORD_LEN data bits sent LSB first, an optional parity bit, and STOP_BITS stop bits.
// After a beat flagged tlast, the line is held idle for PACKET_GAP_BITS bit-times so that
// receivers can find packet boundaries.
//
// Optional feature: define UART_TX_PARITY_EN to send one parity bit between the data
// and stop bits. PARITY_ODD selects its sense. Without the macro, PARITY_ODD is ignored.
//
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-high reset; aborts any frame in progress
//   s_axis_tdata   in   data beat (WORD_LEN bits)
//   s_axis_tvalid  in   beat valid
//   s_axis_tlast   in   last beat of packet
//   s_axis_tready  out  high in IDLE; a beat is accepted on an edge with tvalid & tready
//   uart_tx        out  serial line, idle high, registered
//   busy           out  frame or inter-packet gap in progress
module axis_uart_tx_pkt #(
    parameter int unsigned CLK_RATE        = 100000000,
    parameter int unsigned BAUD            = 115200,
    parameter int unsigned WORD_LEN        = 8,
    parameter int unsigned STOP_BITS       = 1,
    parameter int unsigned PACKET_GAP_BITS = 0,
    parameter bit          PARITY_ODD      = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_LEN-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    input  logic                s_axis_tlast,
    output logic                s_axis_tready,
    output logic                uart_tx,
    output logic                busy
);

    localparam int unsigned BaudDiv = CLK_RATE / BAUD;
    localparam int unsigned BaudW   = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
    localparam int unsigned MaxWs   = (WORD_LEN > STOP_BITS) ? WORD_LEN : STOP_BITS;
    localparam int unsigned CntMax  = (MaxWs > PACKET_GAP_BITS) ? MaxWs : PACKET_GAP_BITS;
    localparam int unsigned BitW    = $clog2(CntMax + 1);
    // Keeps the compare constant legal when the gap is disabled; GAP is then unreachable.
    localparam int unsigned GapLast = (PACKET_GAP_BITS > 0) ? PACKET_GAP_BITS - 1 : 0;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4,
        StGap    = 3'd5
    } state_e;

    state_e              r_state_q, w_state_d;
    logic [BaudW-1:0]    r_baud_q, w_baud_d;
    logic [BitW-1:0]     r_bit_q, w_bit_d;
    logic [WORD_LEN-1:0] r_shift_q, w_shift_d;
    logic                r_last_q, w_last_d;
    logic                r_tx_q, w_tx_d;
    logic                w_bit_end;
`ifdef UART_TX_PARITY_EN
    logic                r_par_q, w_par_d;
`else
    logic                w_unused_parity_odd;
    assign w_unused_parity_odd = PARITY_ODD;
`endif

    assign w_bit_end = (r_baud_q == BaudW'(BaudDiv - 1));

    always_comb begin
        w_state_d = r_state_q;
        w_shift_d = r_shift_q;
        w_last_d  = r_last_q;
`ifdef UART_TX_PARITY_EN
        w_par_d   = r_par_q;
`endif
        case (r_state_q)
            StIdle: begin
                if (s_axis_tvalid) begin
                    w_state_d = StStart;
                    w_shift_d = s_axis_tdata;
                    w_last_d  = s_axis_tlast;
`ifdef UART_TX_PARITY_EN
                    // Parity is taken from the captured word; the shifter is consumed later.
                    w_par_d   = (^s_axis_tdata) ^ PARITY_ODD;
`endif
                end
            end
            StStart: begin
                if (w_bit_end) w_state_d = StData;
            end
            StData: begin
                if (w_bit_end) begin
                    w_shift_d = r_shift_q >> 1;
                    if (r_bit_q == BitW'(WORD_LEN - 1)) begin
`ifdef UART_TX_PARITY_EN
                        w_state_d = StParity;
`else
                        w_state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (w_bit_end) w_state_d = StStop;
            end
`endif
            StStop: begin
                if (w_bit_end && (r_bit_q == BitW'(STOP_BITS - 1))) begin
                    w_state_d = (r_last_q && (PACKET_GAP_BITS > 0)) ? StGap : StIdle;
                end
            end
            StGap: begin
                if (w_bit_end && (r_bit_q == BitW'(GapLast))) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Both counters restart on every state change so each state begins on a bit boundary.
    always_comb begin
        w_baud_d = r_baud_q;
        w_bit_d  = r_bit_q;
        if (w_state_d != r_state_q) begin
            w_baud_d = '0;
            w_bit_d  = '0;
        end else if (r_state_q != StIdle) begin
            if (w_bit_end) begin
                w_baud_d = '0;
                w_bit_d  = r_bit_q + BitW'(1);
            end else begin
                w_baud_d = r_baud_q + BaudW'(1);
            end
        end
    end

    // Line level is decoded from the next state so it changes on the same edge as the state.
    always_comb begin
        w_tx_d = 1'b1;
        case (w_state_d)
            StStart:  w_tx_d = 1'b0;
            StData:   w_tx_d = w_shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: w_tx_d = w_par_d;
`endif
            default:  w_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= StIdle;
            r_baud_q  <= '0;
            r_bit_q   <= '0;
            r_shift_q <= '0;
            r_last_q  <= 1'b0;
            r_tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par_q   <= 1'b0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_baud_q  <= w_baud_d;
            r_bit_q   <= w_bit_d;
            r_shift_q <= w_shift_d;
            r_last_q  <= w_last_d;
            r_tx_q    <= w_tx_d;
`ifdef UART_TX_PARITY_EN
            r_par_q   <= w_par_d;
`endif
        end
    end

    assign s_axis_tready = (r_state_q == StIdle);
    assign busy          = (r_state_q != StIdle);
    assign uart_tx       = r_tx_q;

endmodule

// File: doc/axis_uart_tx_pkt.md
# axis_uart_tx_pkt

Parametrised AXI-Stream-to-UART transmitter. It serialises one WORD_LEN-bit beat per frame, LSB first, with a configurable number of stop bits and optional parity. After a beat flagged tlast it inserts a programmable idle gap so that downstream receivers can find packet boundaries. It sits between the packet formatter's AXI-Stream master and the chip's TX pad, and is the next-generation replacement for the fixed 8N1 transmitter.

## Interface
- CLK_RATE, 100000000: clock frequency in Hz.
- BAUD, 115200: line rate in bit/s. BAUD_DIV = CLK_RATE/BAUD (integer division) and must be ≥ 2.
- WORD_LEN, 8: data bits per frame, legal range 5..9.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- PACKET_GAP_BITS, 0: idle bit-times inserted after a tlast beat, range 0..15; 0 disables the gap.
- PARITY_ODD, 0: parity sense, 0 = even, 1 = odd. Used only with UART_TX_PARITY_EN.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- s_axis_tdata  in  WORD_LEN  data beat.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tready  out  1  beat accepted on the edge where tvalid&tready=1.
- uart_tx  out  1  serial line, idle high, registered.
- busy  out  1  frame or gap in progress.

## Operation
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP, GAP.
- s_axis_tready = (state==IDLE); busy = (state!=IDLE). Both are decoded from the state register only; there is no combinational path from tvalid.
- IDLE: uart_tx=1. On accept, capture tdata into the shift register and tlast into last_q; go to START.
- Baud counter counts 0..BAUD_DIV-1 and is cleared on every state change. Each bit lasts exactly BAUD_DIV cycles.
- START: uart_tx=0 for 1 bit-time, then DATA.
- DATA: uart_tx=shift[0]; shift right at each bit end. After WORD_LEN bits go to PARITY (if the macro is defined) else STOP.
- PARITY: 1 bit-time. Bit value = ^data (even) or ~^data (odd), computed on the captured word.
- STOP: uart_tx=1 for STOP_BITS bit-times. Then go to GAP if last_q && PACKET_GAP_BITS>0, else IDLE.
- GAP: uart_tx=1 for PACKET_GAP_BITS bit-times, then IDLE.
- Bit counter width is $clog2(max(WORD_LEN,STOP_BITS,PACKET_GAP_BITS)+1). It is reused in DATA, STOP and GAP and cleared on each state change.
- tdata, tlast and tvalid are ignored outside IDLE. A beat offered while busy waits; it is never dropped.
- Reset mid-frame aborts the frame immediately and the captured data is lost. No partial frame is resumed.

## Timing
- Reset values: uart_tx=1, s_axis_tready=1, busy=0, state=IDLE, all counters 0, shift register 0, last_q=0.
- Let E0 be the accept edge. uart_tx goes low on E0 (registered with the state change).
- Frame length N = 1 + WORD_LEN + P + STOP_BITS, where P=1 with parity, else 0. IDLE is re-entered at edge E0 + N*BAUD_DIV.
- After a tlast beat with a gap, IDLE is re-entered at E0 + (N+PACKET_GAP_BITS)*BAUD_DIV.
- With tvalid held high, consecutive accepts are N*BAUD_DIV+1 cycles apart. The extra IDLE cycle stretches the stop bit by 1 clk.
- Throughput: one beat per N*BAUD_DIV+1 cycles (+ the gap after tlast). Accept-to-first-line-transition latency is 0 cycles after the edge.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state exists and one parity bit (sense set by PARITY_ODD) is sent between data and stop bits, so N grows by 1.
- UART_TX_PARITY_EN undefined: no PARITY state and no parity logic. PARITY_ODD is ignored and frames are WORD_LEN-N-STOP_BITS.

## Test plan
All scenarios use CLK_RATE=100000000 and BAUD=10000000 (BAUD_DIV=10), WORD_LEN=8, STOP_BITS=1, no macro unless stated.
- Reset: assert rst for 3 cycles with tvalid=1 -> uart_tx=1, tready=1, busy=0 throughout; nothing is transmitted until rst falls.
- Single beat 0xA5, tlast=0 -> line 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles; tready high again 100 cycles after E0.
- Parity: with UART_TX_PARITY_EN, beat 0x07 -> parity bit 1 (even) or 0 (PARITY_ODD=1); tready returns at E0+110.
- Back-to-back: tvalid held with 0x55 then 0xAA, STOP_BITS=2 -> second accept at E0+111; line stays high for 21 cycles between the frames' data.
- Packet gap: PACKET_GAP_BITS=2, beat 0x3C with tlast=1 -> line high from E0+90 to E0+120, busy=1 until E0+120, tready=1 at E0+120.
- Reset mid-DATA: assert rst at E0+45 -> uart_tx=1 and tready=1 asynchronously. After release, beat 0x81 is transmitted as a complete, correct frame.
